payload_reader: RTL and testbench

Downstream consumer of the packet payload memory controller. Accepts one descriptor per buffered payload (slot id, byte length) and issues word reads to the memory read port, which has 1-cycle latency. Returns the payload as a valid/ready beat stream with byte keep and last flags. On completion it pulses a slot-release signal so upstream can recycle the slot.

---
 rtl/payload_reader.sv | 240 ++++++++++++++++++++++++
 tb/tb_payload_reader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/payload_reader.sv
// Payload reader: turns (slot id, byte length) descriptors into word reads on a
// 1-cycle-latency memory port and streams the words out as keep/last beats.
module payload_reader #(
    parameter int BUS_WIDTH   = 32,
    parameter int ID_WIDTH    = 4,
    parameter int LEN_WIDTH   = 16,
    parameter int WADDR_WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   desc_valid,
    output logic                   desc_ready,
    input  logic [ID_WIDTH-1:0]    desc_id,
    input  logic [LEN_WIDTH-1:0]   desc_len,
    output logic                   mem_ren,
    output logic [ID_WIDTH-1:0]    mem_id,
    output logic [WADDR_WIDTH-1:0] mem_addr,
    input  logic [BUS_WIDTH-1:0]   mem_rdata,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [BUS_WIDTH-1:0]   m_data,
    output logic [BUS_WIDTH/8-1:0] m_keep,
    output logic                   m_last,
    output logic [ID_WIDTH-1:0]    m_id,
    output logic                   free_valid,
    output logic [ID_WIDTH-1:0]    free_id
);

    localparam int B  = BUS_WIDTH / 8;
    localparam int WW = LEN_WIDTH + 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    // Keep mask of the final word: low (len mod B) bytes, or the full word.
    function automatic logic [B-1:0] last_keep(input logic [LEN_WIDTH-1:0] len);
        logic [B-1:0]         k;
        logic [LEN_WIDTH-1:0] r;
        r = len % LEN_WIDTH'(B);
        for (int i = 0; i < B; i++) begin
            k[i] = (r == '0) || (LEN_WIDTH'(i) < r);
        end
        return k;
    endfunction

    state_t               state_q, state_d;
    logic [ID_WIDTH-1:0]  id_q, id_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [WW-1:0]        words_q, words_d;
    logic [WW-1:0]        rd_ptr_q, rd_ptr_d;

    logic                 inflight_q;
    logic                 tag_last_q;
    logic [B-1:0]         tag_keep_q;
    logic [ID_WIDTH-1:0]  tag_id_q;

    logic [BUS_WIDTH-1:0] fifo_data_q [0:1];
    logic [B-1:0]         fifo_keep_q [0:1];
    logic                 fifo_last_q [0:1];
    logic [ID_WIDTH-1:0]  fifo_id_q   [0:1];
    logic                 wr_sel_q;
    logic                 rd_sel_q;
    logic [1:0]           count_q, count_d;

    logic                 free_valid_q;
    logic [ID_WIDTH-1:0]  free_id_q;

    logic                 desc_ready_s;
    logic                 mem_ren_s;
    logic                 desc_hs_s;
    logic                 credit_ok_s;
    logic                 last_issue_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 m_valid_s;
    logic [WW-1:0]        desc_words_s;

    assign desc_hs_s    = desc_valid & desc_ready_s;
    assign desc_words_s = (WW'(desc_len) + WW'(B - 1)) / WW'(B);
    assign last_issue_s = (rd_ptr_q == (words_q - WW'(1)));
    assign push_s       = inflight_q;
    assign m_valid_s    = (count_q != 2'd0);
    assign pop_s        = m_valid_s & m_ready;
    // A word in flight lands next cycle, so it must already own a FIFO slot.
    assign credit_ok_s  = ({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_s});

    // State register and descriptor context.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            id_q     <= '0;
            len_q    <= '0;
            words_q  <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            len_q    <= len_d;
            words_q  <= words_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Next-state logic: accept a descriptor, then walk the word pointer.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        len_d    = len_q;
        words_d  = words_q;
        rd_ptr_d = rd_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (desc_hs_s) begin
                    id_d  = desc_id;
                    len_d = desc_len;
                    if (desc_len != '0) begin
                        words_d  = desc_words_s;
                        rd_ptr_d = '0;
                        state_d  = S_READ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (mem_ren_s) begin
                    rd_ptr_d = rd_ptr_q + WW'(1);
                    if (last_issue_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_READ;
                    end
                end else begin
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs: descriptor ready in IDLE, reads gated by credit in READ.
    always_comb begin
        desc_ready_s = 1'b0;
        mem_ren_s    = 1'b0;
        case (state_q)
            S_IDLE:  desc_ready_s = 1'b1;
            S_READ:  mem_ren_s    = credit_ok_s;
            default: begin
                desc_ready_s = 1'b0;
                mem_ren_s    = 1'b0;
            end
        endcase
    end

    // Side tag travels with the read so it meets mem_rdata one cycle later.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            inflight_q <= 1'b0;
            tag_last_q <= 1'b0;
            tag_keep_q <= '0;
            tag_id_q   <= '0;
        end else begin
            inflight_q <= mem_ren_s;
            if (mem_ren_s) begin
                tag_last_q <= last_issue_s;
                tag_keep_q <= last_issue_s ? last_keep(len_q) : {B{1'b1}};
                tag_id_q   <= id_q;
            end
        end
    end

    // FIFO occupancy update.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Two-entry output FIFO storage and pointers.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_keep_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
                fifo_id_q[i]   <= '0;
            end
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_data_q[wr_sel_q] <= mem_rdata;
                fifo_keep_q[wr_sel_q] <= tag_keep_q;
                fifo_last_q[wr_sel_q] <= tag_last_q;
                fifo_id_q[wr_sel_q]   <= tag_id_q;
                wr_sel_q              <= ~wr_sel_q;
            end
            if (pop_s) begin
                rd_sel_q <= ~rd_sel_q;
            end
            count_q <= count_d;
        end
    end

    // Slot release pulse follows the handshake of a packet's last beat.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            free_valid_q <= 1'b0;
            free_id_q    <= '0;
        end else begin
            free_valid_q <= pop_s & fifo_last_q[rd_sel_q];
            if (pop_s & fifo_last_q[rd_sel_q]) begin
                free_id_q <= fifo_id_q[rd_sel_q];
            end
        end
    end

    assign desc_ready = desc_ready_s;
    assign mem_ren    = mem_ren_s;
    assign mem_id     = id_q;
    assign mem_addr   = rd_ptr_q[WADDR_WIDTH-1:0];
    assign m_valid    = m_valid_s;
    assign m_data     = fifo_data_q[rd_sel_q];
    assign m_keep     = fifo_keep_q[rd_sel_q];
    assign m_last     = fifo_last_q[rd_sel_q];
    assign m_id       = fifo_id_q[rd_sel_q];
    assign free_valid = free_valid_q;
    assign free_id    = free_id_q;

endmodule

// File: tb/tb_payload_reader.sv
// Directed bench for payload_reader: memory model, beat/free scoreboards and
// a negedge monitor that checks order, credit and backpressure stability.
module tb_payload_reader;

    logic        CLK = 1'b0;
    logic        reset;
    logic        desc_valid;
    logic        desc_ready;
    logic [3:0]  desc_id;
    logic [15:0] desc_len;
    logic        mem_ren;
    logic [3:0]  mem_id;
    logic [7:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic [3:0]  m_id;
    logic        free_valid;
    logic [3:0]  free_id;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    beat_t      exp_q[$];
    logic [3:0] free_q[$];
    int         beat_cyc_q[$];
    int         checks = 0;
    int         passed = 0;
    int         cyc = 0;
    int         beats_seen = 0;
    int         issued = 0;
    int         popped = 0;

    payload_reader #(
        .BUS_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(16), .WADDR_WIDTH(8)
    ) dut (
        .CLK(CLK), .reset(reset),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_id(desc_id), .desc_len(desc_len),
        .mem_ren(mem_ren), .mem_id(mem_id), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_keep(m_keep), .m_last(m_last), .m_id(m_id),
        .free_valid(free_valid), .free_id(free_id)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] pattern(input logic [3:0] id, input logic [7:0] a);
        return {8'hA5, 4'h0, id, 8'h3C, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // 1-cycle-latency memory read port
    always @(posedge CLK) begin
        if (mem_ren) mem_rdata <= pattern(mem_id, mem_addr);
    end

    logic        prev_stall = 1'b0;
    logic [41:0] prev_out;

    always @(negedge CLK) begin
        beat_t e;
        int    pop_now;
        if (!reset) begin
            pop_now = (m_valid && m_ready) ? 1 : 0;
            if (prev_stall)
                chk("hold_stable", 64'({m_valid, m_data, m_keep, m_last, m_id}), 64'(prev_out));
            if (mem_ren) begin
                chk("credit", 64'((issued - popped + 1 - pop_now) <= 2), 64'd1);
                issued++;
            end
            if (m_valid && m_ready) begin
                chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("beat", 64'({m_data, m_keep, m_last, m_id}), 64'(e));
                end
                popped++;
                beats_seen++;
                beat_cyc_q.push_back(cyc);
            end
            if (free_valid) begin
                chk("free_expected", 64'(free_q.size() != 0), 64'd1);
                if (free_q.size() != 0) chk("free_id", 64'(free_id), 64'(free_q.pop_front()));
            end
            prev_stall = m_valid && !m_ready;
            prev_out   = {m_valid, m_data, m_keep, m_last, m_id};
        end else begin
            prev_stall = 1'b0;
            issued     = 0;
            popped     = 0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(desc_ready), 64'd1);
        chk({tag, "_mem"}, 64'({mem_ren, mem_id, mem_addr}), 64'd0);
        chk({tag, "_beat"}, 64'({m_valid, m_data, m_keep, m_last, m_id}), 64'd0);
        chk({tag, "_free"}, 64'({free_valid, free_id}), 64'd0);
    endtask

    task automatic send_desc(input logic [3:0] id, input logic [15:0] len);
        int    words;
        int    r;
        bit    hs;
        beat_t e;
        words = (int'(len) + 3) / 4;
        r     = int'(len) % 4;
        for (int w = 0; w < words; w++) begin
            e.data = pattern(id, 8'(w));
            e.last = (w == words - 1);
            e.keep = (e.last && r != 0) ? (4'hF >> (4 - r)) : 4'hF;
            e.id   = id;
            exp_q.push_back(e);
        end
        if (len != 16'd0) free_q.push_back(id);
        desc_valid = 1'b1;
        desc_id    = id;
        desc_len   = len;
        hs = 1'b0;
        for (int k = 0; k < 200 && !hs; k++) begin
            @(negedge CLK);
            if (desc_ready) hs = 1'b1;
            else begin @(posedge CLK); #1; end
        end
        chk("desc_accepted", 64'(hs), 64'd1);
        @(posedge CLK); #1;
        desc_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && free_q.size() == 0) done = 1'b1;
        end
        chk({tag, "_drained"}, 64'(exp_q.size() + free_q.size()), 64'd0);
        @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit seen;
        reset = 1'b1; desc_valid = 1'b0; desc_id = 4'd0; desc_len = 16'd0;
        m_ready = 1'b1; mem_rdata = 32'd0;
        #12;
        check_reset_outputs("reset");
        @(posedge CLK); #1;
        reset = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end

        // len=10: three reads, keep 1111/1111/0011, free one cycle after last beat
        send_desc(4'd3, 16'd10);
        @(negedge CLK);
        chk("t1_read0", 64'({mem_ren, mem_id, mem_addr}), 64'({1'b1, 4'd3, 8'd0}));
        chk("t1_no_beat_t1", 64'(m_valid), 64'd0);
        @(negedge CLK);
        chk("t1_read1", 64'({mem_ren, mem_id, mem_addr}), 64'({1'b1, 4'd3, 8'd1}));
        chk("t1_no_beat_t2", 64'(m_valid), 64'd0);
        @(negedge CLK);
        chk("t1_read2", 64'({mem_ren, mem_id, mem_addr}), 64'({1'b1, 4'd3, 8'd2}));
        chk("t1_beat_t3", 64'(m_valid), 64'd1);
        @(negedge CLK);
        chk("t1_reads_done", 64'(mem_ren), 64'd0);
        @(negedge CLK);
        chk("t1_last_beat", 64'({m_valid, m_last, m_keep}), 64'({1'b1, 1'b1, 4'b0011}));
        @(negedge CLK);
        chk("t1_free_pulse", 64'({free_valid, free_id}), 64'({1'b1, 4'd3}));
        @(negedge CLK);
        chk("t1_free_one_cycle", 64'(free_valid), 64'd0);
        @(posedge CLK); #1;
        wait_drain("t1");

        // len=8 / len=0 / len=1 back to back
        send_desc(4'd1, 16'd8);
        send_desc(4'd2, 16'd0);
        @(negedge CLK);
        chk("t2_len0_idle", 64'({desc_ready, mem_ren}), 64'({1'b1, 1'b0}));
        @(posedge CLK); #1;
        send_desc(4'd5, 16'd1);
        wait_drain("t2");

        // len=40 under random backpressure with a 5-cycle stall
        send_desc(4'd9, 16'd40);
        for (int i = 0; i < 6; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            @(posedge CLK); #1;
        end
        m_ready = 1'b0;
        repeat (4) begin @(posedge CLK); #1; end
        @(negedge CLK);
        chk("t3_stall_no_read", 64'({m_valid, mem_ren}), 64'({1'b1, 1'b0}));
        @(posedge CLK); #1;
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            @(posedge CLK); #1;
        end
        m_ready = 1'b1;
        wait_drain("t3");

        // two len=16 packets: 8 beats with exactly one bubble
        beat_cyc_q.delete();
        send_desc(4'd7, 16'd16);
        send_desc(4'd8, 16'd16);
        wait_drain("t4");
        chk("t4_beat_count", 64'(beat_cyc_q.size()), 64'd8);
        if (beat_cyc_q.size() == 8)
            chk("t4_span", 64'(beat_cyc_q[7] - beat_cyc_q[0]), 64'd8);

        // asynchronous reset after the second beat of a len=32 packet
        base = beats_seen;
        send_desc(4'd4, 16'd32);
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge CLK);
            if (beats_seen >= base + 2) seen = 1'b1;
        end
        chk("t5_two_beats", 64'(seen), 64'd1);
        @(posedge CLK); #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("t5_async");
        exp_q.delete();
        free_q.delete();
        @(posedge CLK); #1;
        reset = 1'b0;
        @(posedge CLK); #1;
        send_desc(4'd6, 16'd8);
        @(negedge CLK);
        chk("t5_restart_addr0", 64'({mem_ren, mem_id, mem_addr}), 64'({1'b1, 4'd6, 8'd0}));
        @(posedge CLK); #1;
        wait_drain("t5");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
